// File: rtl/regfile_write_port_pkg.sv
// regfile_write_port_pkg: shared widths and entry type for the writeback queue.
// Forwarding logic elsewhere is enabled by defining REGFILE_WP_FWD_EN.
package regfile_write_port_pkg;

   localparam int REG_ID_W = 4;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;

   localparam logic [REG_ID_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [REG_ID_W-1:0] dst;
      logic [DATA_W-1:0]   data;
   } wbq_entry_t;

   // register 0 is hardwired, so writes to it are dropped
   function automatic logic is_live_reg(input logic [REG_ID_W-1:0] r);
      return r != ZERO_REG;
   endfunction

endpackage

// File: rtl/regfile_write_port_if.sv
// regfile_write_port_if: producer handshakes, regfile write port, forwarding.
// fwd ports always exist; they only carry data under REGFILE_WP_FWD_EN.
interface regfile_write_port_if #(
   parameter int DEPTH = 4
);
   import regfile_write_port_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                alu_vld;
   logic [REG_ID_W-1:0] alu_reg;
   logic [DATA_W-1:0]   alu_data;
   logic                alu_rdy;

   logic                mem_vld;
   logic [REG_ID_W-1:0] mem_reg;
   logic [DATA_W-1:0]   mem_data;
   logic                mem_rdy;

   logic [REG_ID_W-1:0] DstReg;
   logic                WriteReg;
   logic [DATA_W-1:0]   DstData;

   logic [REG_ID_W-1:0] src1_reg;
   logic [REG_ID_W-1:0] src2_reg;
   logic                fwd1_hit;
   logic                fwd2_hit;
   logic [DATA_W-1:0]   fwd1_data;
   logic [DATA_W-1:0]   fwd2_data;

   logic                empty;
   logic [CNT_W-1:0]    count;

   modport slave (
      input  alu_vld, alu_reg, alu_data,
      output alu_rdy,
      input  mem_vld, mem_reg, mem_data,
      output mem_rdy,
      output DstReg, WriteReg, DstData,
      input  src1_reg, src2_reg,
      output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
      output empty, count
   );

   modport master (
      output alu_vld, alu_reg, alu_data,
      input  alu_rdy,
      output mem_vld, mem_reg, mem_data,
      input  mem_rdy,
      input  DstReg, WriteReg, DstData,
      output src1_reg, src2_reg,
      input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
      input  empty, count
   );

endinterface

// File: rtl/regfile_write_port_fwd_match.sv
// wbq_fwd_match: youngest pending queue entry matching one read register.
// Only compiled when REGFILE_WP_FWD_EN is defined.
`ifdef REGFILE_WP_FWD_EN
module wbq_fwd_match
   import regfile_write_port_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  wbq_entry_t          entries [DEPTH],
   input  logic [DEPTH-1:0]    occ,
   input  logic [PTR_W-1:0]    head,
   input  logic [REG_ID_W-1:0] src,
   output logic                hit,
   output logic [DATA_W-1:0]   data
);

   logic [PTR_W-1:0] idx;

   // scan oldest to youngest so the last match kept is the youngest
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (occ[idx] && is_live_reg(src) &&
             entries[idx].dst == src) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule
`endif

// File: rtl/regfile_write_port.sv
// regfile_write_port: two-producer in-order writeback queue, one write/cycle.
// Define REGFILE_WP_FWD_EN to compile in read-port forwarding.
module regfile_write_port
   import regfile_write_port_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_write_port_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wbq_entry_t       entries_q [DEPTH];
   wbq_entry_t       entries_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [CNT_W-1:0] free;
   logic             mem_acc, alu_acc;
   logic             mem_enq, alu_enq;
   logic [1:0]       enq_cnt;
   logic             deq;
   logic [PTR_W-1:0] wr_ptr;

   // credit comes only from registered occupancy; mem wins the last slot
   always_comb begin
      free        = CNT_W'(DEPTH) - count_q;
      bus.mem_rdy = free >= CNT_W'(1);
      bus.alu_rdy = (free >= CNT_W'(2)) ||
                    ((free == CNT_W'(1)) && !bus.mem_vld);
   end

   // accepted requests to r0 finish the handshake but take no slot
   always_comb begin
      mem_acc = bus.mem_vld && bus.mem_rdy;
      alu_acc = bus.alu_vld && bus.alu_rdy;
      mem_enq = mem_acc && is_live_reg(bus.mem_reg);
      alu_enq = alu_acc && is_live_reg(bus.alu_reg);
      enq_cnt = {1'b0, mem_enq} + {1'b0, alu_enq};
      deq     = count_q != '0;
   end

   // mem entry lands first (older), ALU entry behind it
   always_comb begin
      entries_d = entries_q;
      wr_ptr    = tail_q;
      if (mem_enq) begin
         entries_d[wr_ptr] = '{dst: bus.mem_reg, data: bus.mem_data};
         wr_ptr = wr_ptr + 1'b1;
      end
      if (alu_enq) begin
         entries_d[wr_ptr] = '{dst: bus.alu_reg, data: bus.alu_data};
         wr_ptr = wr_ptr + 1'b1;
      end
      tail_d = wr_ptr;
   end

   // head pops whenever something is presented on the write port
   always_comb begin
      head_d  = head_q + PTR_W'(deq);
      count_d = count_q + CNT_W'(enq_cnt) - CNT_W'(deq);
   end

   // queue state; reset drops any pending entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

   // head entry drives the register file write port
   always_comb begin
      bus.WriteReg = count_q != '0;
      bus.DstReg   = '0;
      bus.DstData  = '0;
      if (bus.WriteReg) begin
         bus.DstReg  = entries_q[head_q].dst;
         bus.DstData = entries_q[head_q].data;
      end
      bus.empty = count_q == '0;
      bus.count = count_q;
   end

`ifdef REGFILE_WP_FWD_EN
   logic [DEPTH-1:0] occ;
   logic [PTR_W-1:0] rel;

   // slot k is live when its distance from head is below occupancy
   always_comb begin
      occ = '0;
      rel = '0;
      for (int k = 0; k < DEPTH; k++) begin
         rel    = PTR_W'(k) - head_q;
         occ[k] = CNT_W'(rel) < count_q;
      end
   end

   wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .entries (entries_q),
      .occ     (occ),
      .head    (head_q),
      .src     (bus.src1_reg),
      .hit     (bus.fwd1_hit),
      .data    (bus.fwd1_data)
   );

   wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .entries (entries_q),
      .occ     (occ),
      .head    (head_q),
      .src     (bus.src2_reg),
      .hit     (bus.fwd2_hit),
      .data    (bus.fwd2_data)
   );
`else
   logic unused_src;

   // without forwarding the read-side lookups are idle
   always_comb begin
      unused_src    = ^{bus.src1_reg, bus.src2_reg};
      bus.fwd1_hit  = 1'b0;
      bus.fwd2_hit  = 1'b0;
      bus.fwd1_data = '0;
      bus.fwd2_data = '0;
   end
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port: directed scenarios for the writeback queue.
// Forwarding expectations follow REGFILE_WP_FWD_EN.
module tb_regfile_write_port;

`ifdef REGFILE_WP_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   regfile_write_port_if #(.DEPTH(4)) bus ();

   regfile_write_port #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic idle_inputs();
      bus.alu_vld  = 1'b0;
      bus.alu_reg  = '0;
      bus.alu_data = '0;
      bus.mem_vld  = 1'b0;
      bus.mem_reg  = '0;
      bus.mem_data = '0;
      bus.src1_reg = '0;
      bus.src2_reg = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
      n_chk++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.count); end
      n_chk++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.WriteReg); end
      n_chk++; if (bus.DstReg !== 4'h0 || bus.DstData !== 16'h0) begin n_fail++; $display("FAIL rst_dst: got %h/%h want 0/0000", bus.DstReg, bus.DstData); end
      n_chk++; if (bus.alu_rdy !== 1'b1 || bus.mem_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b%b want 11", bus.alu_rdy, bus.mem_rdy); end
      n_chk++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin n_fail++; $display("FAIL rst_fwd: got %b%b want 00", bus.fwd1_hit, bus.fwd2_hit); end
   endtask

   task automatic test_single_alu();
      @(negedge clk);
      bus.alu_vld  = 1'b1;
      bus.alu_reg  = 4'd3;
      bus.alu_data = 16'hBEEF;
      bus.src1_reg = 4'd3;
      #1;
      n_chk++; if (bus.alu_rdy !== 1'b1) begin n_fail++; $display("FAIL s1_rdy: got %b want 1", bus.alu_rdy); end
      n_chk++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL s1_we_early: got %b want 0", bus.WriteReg); end
      @(negedge clk);
      bus.alu_vld = 1'b0;
      #1;
      n_chk++; if (bus.WriteReg !== 1'b1) begin n_fail++; $display("FAIL s1_we: got %b want 1", bus.WriteReg); end
      n_chk++; if (bus.DstReg !== 4'd3 || bus.DstData !== 16'hBEEF) begin n_fail++; $display("FAIL s1_dst: got %h/%h want 3/beef", bus.DstReg, bus.DstData); end
      n_chk++; if (bus.count !== 3'd1) begin n_fail++; $display("FAIL s1_count: got %0d want 1", bus.count); end
      n_chk++; if (bus.fwd1_hit !== FWD || bus.fwd1_data !== (FWD ? 16'hBEEF : 16'h0)) begin n_fail++; $display("FAIL s1_fwd: got %b/%h want %b", bus.fwd1_hit, bus.fwd1_data, FWD); end
      @(negedge clk);
      #1;
      n_chk++; if (bus.empty !== 1'b1 || bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL s1_drained: got empty %b we %b want 1 0", bus.empty, bus.WriteReg); end
      n_chk++; if (bus.DstData !== 16'h0) begin n_fail++; $display("FAIL s1_data_idle: got %h want 0000", bus.DstData); end
   endtask

   task automatic test_dual_same_reg();
      @(negedge clk);
      bus.mem_vld  = 1'b1;
      bus.mem_reg  = 4'd5;
      bus.mem_data = 16'h1111;
      bus.alu_vld  = 1'b1;
      bus.alu_reg  = 4'd5;
      bus.alu_data = 16'h2222;
      bus.src1_reg = 4'd5;
      bus.src2_reg = 4'd3;
      #1;
      n_chk++; if (bus.alu_rdy !== 1'b1 || bus.mem_rdy !== 1'b1) begin n_fail++; $display("FAIL s2_rdy: got %b%b want 11", bus.alu_rdy, bus.mem_rdy); end
      n_chk++; if (bus.fwd1_hit !== 1'b0) begin n_fail++; $display("FAIL s2_fwd_same_cycle: got %b want 0", bus.fwd1_hit); end
      @(negedge clk);
      bus.mem_vld = 1'b0;
      bus.alu_vld = 1'b0;
      #1;
      n_chk++; if (bus.count !== 3'd2) begin n_fail++; $display("FAIL s2_count: got %0d want 2", bus.count); end
      n_chk++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd5 || bus.DstData !== 16'h1111) begin n_fail++; $display("FAIL s2_first: got %b %h/%h want 1 5/1111", bus.WriteReg, bus.DstReg, bus.DstData); end
      n_chk++; if (bus.fwd1_hit !== FWD || bus.fwd1_data !== (FWD ? 16'h2222 : 16'h0)) begin n_fail++; $display("FAIL s2_fwd_young: got %b/%h want %b", bus.fwd1_hit, bus.fwd1_data, FWD); end
      n_chk++; if (bus.fwd2_hit !== 1'b0 || bus.fwd2_data !== 16'h0) begin n_fail++; $display("FAIL s2_fwd2_miss: got %b/%h want 0/0000", bus.fwd2_hit, bus.fwd2_data); end
      @(negedge clk);
      #1;
      n_chk++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd5 || bus.DstData !== 16'h2222) begin n_fail++; $display("FAIL s2_second: got %b %h/%h want 1 5/2222", bus.WriteReg, bus.DstReg, bus.DstData); end
      n_chk++; if (bus.fwd1_hit !== FWD || bus.fwd1_data !== (FWD ? 16'h2222 : 16'h0)) begin n_fail++; $display("FAIL s2_fwd_last: got %b/%h want %b", bus.fwd1_hit, bus.fwd1_data, FWD); end
      @(negedge clk);
      #1;
      n_chk++; if (bus.empty !== 1'b1 || bus.fwd1_hit !== 1'b0) begin n_fail++; $display("FAIL s2_done: got empty %b hit %b want 1 0", bus.empty, bus.fwd1_hit); end
   endtask

   task automatic test_reg_zero();
      @(negedge clk);
      bus.alu_vld  = 1'b1;
      bus.alu_reg  = 4'd0;
      bus.alu_data = 16'hFFFF;
      bus.mem_vld  = 1'b1;
      bus.mem_reg  = 4'd0;
      bus.mem_data = 16'hFFFF;
      bus.src1_reg = 4'd0;
      #1;
      n_chk++; if (bus.alu_rdy !== 1'b1 || bus.mem_rdy !== 1'b1) begin n_fail++; $display("FAIL z_rdy: got %b%b want 11", bus.alu_rdy, bus.mem_rdy); end
      @(negedge clk);
      bus.alu_vld = 1'b0;
      bus.mem_vld = 1'b0;
      #1;
      n_chk++; if (bus.count !== 3'd0 || bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL z_dropped: got count %0d we %b want 0 0", bus.count, bus.WriteReg); end
      n_chk++; if (bus.fwd1_hit !== 1'b0) begin n_fail++; $display("FAIL z_fwd: got %b want 0", bus.fwd1_hit); end
      @(negedge clk);
      #1;
      n_chk++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL z_we_late: got %b want 0", bus.WriteReg); end
   endtask

   task automatic test_back_to_back();
      logic [19:0] expq[$];
      int          mcount;
      int          mfree;
      bit          exp_mem;
      bit          exp_alu;
      bit          saw_block;
      mcount    = 0;
      saw_block = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         bus.mem_vld  = (c < 12) && (c != 8);
         bus.mem_reg  = 4'(1 + c % 7);
         bus.mem_data = 16'hA000 + 16'(c);
         bus.alu_vld  = c < 12;
         bus.alu_reg  = 4'(8 + c % 7);
         bus.alu_data = 16'hB000 + 16'(c);
         #1;
         mfree   = 4 - mcount;
         exp_mem = mfree >= 1;
         exp_alu = (mfree >= 2) || (mfree == 1 && !bus.mem_vld);
         if (bus.alu_vld && !exp_alu) saw_block = 1'b1;
         n_chk++; if (bus.mem_rdy !== exp_mem || bus.alu_rdy !== exp_alu) begin n_fail++; $display("FAIL bb_rdy c%0d: got %b%b want %b%b", c, bus.mem_rdy, bus.alu_rdy, exp_mem, exp_alu); end
         n_chk++; if (bus.count !== 3'(mcount) || bus.count > 3'd4) begin n_fail++; $display("FAIL bb_count c%0d: got %0d want %0d", c, bus.count, mcount); end
         n_chk++; if (bus.WriteReg !== (mcount != 0)) begin n_fail++; $display("FAIL bb_we c%0d: got %b want %b", c, bus.WriteReg, mcount != 0); end
         if (mcount != 0) begin
            n_chk++; if ({bus.DstReg, bus.DstData} !== expq[0]) begin n_fail++; $display("FAIL bb_order c%0d: got %h want %h", c, {bus.DstReg, bus.DstData}, expq[0]); end
            void'(expq.pop_front());
         end
         if (bus.mem_vld && exp_mem) expq.push_back({bus.mem_reg, bus.mem_data});
         if (bus.alu_vld && exp_alu) expq.push_back({bus.alu_reg, bus.alu_data});
         mcount = expq.size();
      end
      idle_inputs();
      n_chk++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL bb_alu_blocked: got %b want 1", saw_block); end
      n_chk++; if (mcount != 0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL bb_drained: got empty %b model %0d want 1 0", bus.empty, mcount); end
   endtask

   task automatic test_reset_mid_drain();
      @(negedge clk);
      bus.mem_vld  = 1'b1;
      bus.mem_reg  = 4'd7;
      bus.mem_data = 16'h7777;
      bus.alu_vld  = 1'b1;
      bus.alu_reg  = 4'd8;
      bus.alu_data = 16'h8888;
      @(negedge clk);
      bus.mem_reg  = 4'd10;
      bus.mem_data = 16'hAAAA;
      bus.alu_reg  = 4'd9;
      bus.alu_data = 16'h9999;
      @(negedge clk);
      bus.mem_vld = 1'b0;
      bus.alu_vld = 1'b0;
      #1;
      n_chk++; if (bus.count !== 3'd3 || bus.WriteReg !== 1'b1 || bus.DstData !== 16'h8888) begin n_fail++; $display("FAIL rm_fill: got count %0d we %b data %h want 3 1 8888", bus.count, bus.WriteReg, bus.DstData); end
      #1;
      rst_n = 1'b0;
      #1;
      n_chk++; if (bus.WriteReg !== 1'b0 || bus.DstReg !== 4'h0 || bus.DstData !== 16'h0) begin n_fail++; $display("FAIL rm_async: got %b %h/%h want 0 0/0000", bus.WriteReg, bus.DstReg, bus.DstData); end
      n_chk++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rm_count: got %0d empty %b want 0 1", bus.count, bus.empty); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++; if (bus.count !== 3'd0 || bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL rm_release: got count %0d we %b want 0 0", bus.count, bus.WriteReg); end
      n_chk++; if (bus.alu_rdy !== 1'b1 || bus.mem_rdy !== 1'b1) begin n_fail++; $display("FAIL rm_rdy: got %b%b want 11", bus.alu_rdy, bus.mem_rdy); end
      @(negedge clk);
      #1;
      n_chk++; if (bus.WriteReg !== 1'b0) begin n_fail++; $display("FAIL rm_no_write: got %b want 0", bus.WriteReg); end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_single_alu();
      test_dual_same_reg();
      test_reg_zero();
      test_back_to_back();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_port.md
# regfile_write_port

Write-side front end for the 16x16 register file. Accepts writeback requests from two producers (ALU and memory) over valid/ready handshakes, buffers them in an in-order queue, and drains exactly one entry per cycle onto the register file's single write port (DstReg/WriteReg/DstData). Optionally provides same-cycle forwarding of pending writes to the two read ports, covering the cycles in which a value is queued but not yet visible in the register file.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- alu_vld  in  1  ALU writeback request valid
- alu_reg  in  4  ALU destination register
- alu_data  in  16  ALU writeback data
- alu_rdy  out  1  ALU request accepted this cycle when high with alu_vld
- mem_vld / mem_reg / mem_data / mem_rdy  same widths and meaning, memory producer
- DstReg  out  4  register file write address
- WriteReg  out  1  register file write enable
- DstData  out  16  register file write data
- src1_reg, src2_reg  in  4  read-port register IDs (forwarding lookup)
- fwd1_hit, fwd2_hit  out  1  pending write exists for srcN_reg
- fwd1_data, fwd2_data  out  16  youngest pending data for srcN_reg
- empty  out  1  queue holds no entries
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Storage: circular buffer, DEPTH entries of {reg[3:0], data[15:0]}; head/tail pointers wrap modulo DEPTH; count tracks occupancy.
- free = DEPTH − count (registered count; a same-cycle dequeue does not create credit).
- Acceptance: free ≥ 2 → both rdy high. free == 1 → mem_rdy high; alu_rdy high only if mem_vld low. free == 0 → both rdy low. rdy never depends on the producer's own vld.
- Ordering: when both accepted same cycle, mem entry enqueued first (older), ALU second.
- Register 0: a request with reg == 0 completes its handshake normally but is discarded (not enqueued, consumes no slot, never forwarded).
- Drain: when count > 0, WriteReg = 1, DstReg/DstData = head entry; head pops at the same edge. When empty: WriteReg = 0, DstReg = 4'h0, DstData = 16'h0.
- Forwarding: fwdN_hit = 1 when any occupied entry (head included) has reg == srcN_reg and srcN_reg ≠ 0; fwdN_data = data of the youngest match. No hit → fwdN_data = 16'h0. Entries being enqueued this cycle are not visible until the next cycle.
- Count update: count_next = count + enq_cnt − (count > 0); enq and deq in same cycle at any occupancy are legal.

## Timing
- Accept at edge T → earliest WriteReg assertion in cycle T+1 (register file updates at edge T+2, visible to reads from T+2).
- Throughput: one register file write per cycle; two enqueues per cycle when free ≥ 2.
- Forwarding and rdy outputs are combinational from registered state plus srcN_reg/mem_vld; zero-cycle latency.
- Reset (any time, including mid-drain): queue flushed, pointers 0, count 0, empty 1, WriteReg 0, DstReg 0, DstData 0, fwd hits 0, both rdy 1 after release. Pending entries are lost; no partial write is issued.

## Configuration
- REGFILE_WP_FWD_EN defined: forwarding logic compiled in as described.
- Undefined: forwarding logic absent; fwd1_hit/fwd2_hit tied 0, fwd1_data/fwd2_data tied 16'h0; ports remain in the interface. Queue and drain behaviour unchanged.

## Structure
- Shared package: REG_ID_W = 4, DATA_W = 16, NUM_REGS = 16, typedef wbq_entry_t {reg, data}, zero-register constant.
- One sub-module: wbq_fwd_match — given entry array, occupancy mask, age order and a register ID, returns hit and youngest data; instantiated twice. Compiled only under REGFILE_WP_FWD_EN.

## Test plan
- Reset then single ALU write reg 3 = 16'hBEEF → alu_rdy 1, next cycle WriteReg 1, DstReg 3, DstData 16'hBEEF, then empty 1.
- Same cycle mem reg 5 = 16'h1111 and ALU reg 5 = 16'h2222 → two writes in order 1111 then 2222; fwd on src1_reg = 5 the cycle after enqueue returns 16'h2222.
- Write to reg 0 with data 16'hFFFF → handshake completes, count stays 0, WriteReg never asserted, fwd hit 0 for src 0.
- Producers held valid continuously, DEPTH = 4 → count saturates, free == 1 gives mem priority (alu_rdy 0), count never exceeds 4, writes emerge in acceptance order through pointer wrap-around.
- Fill 3 entries, deassert rst_n mid-drain → outputs zero immediately (async), no further WriteReg, count 0 after release.
- Build without REGFILE_WP_FWD_EN, repeat scenario 2 → fwd hits 0, data 16'h0, register file writes identical.
